// File: rtl/io_decode_sequencer_pkg.sv
// Shared definitions for the IO decode sequencer.
//   state_t        : sequencer state encodings (also driven out on state_o)
//   MAX_LEN        : longest byte pattern the sequencer can match
//   *_W            : widths of the configuration fields and counters
//   eff_len        : maps a raw pattern length onto 1..MAX_LEN
//   eff_stretch    : maps a raw trigger stretch onto 1..127
package io_decode_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_MATCHING = 3'd2,
        ST_FIRE     = 3'd3,
        ST_HOLDOFF  = 3'd4
    } state_t;

    localparam int MAX_LEN    = 8;
    localparam int BYTE_W     = 8;
    localparam int LEN_W      = 4;
    localparam int STRETCH_W  = 7;
    localparam int TIMEOUT_W  = 16;
    localparam int HOLDOFF_W  = 16;
    localparam int TIMER_W    = 16;
    localparam int TRIG_CNT_W = 16;

    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        if (len == '0)
            return LEN_W'(1);
        else if (len > LEN_W'(MAX_LEN))
            return LEN_W'(MAX_LEN);
        else
            return len;
    endfunction

    function automatic logic [STRETCH_W-1:0] eff_stretch(input logic [STRETCH_W-1:0] st);
        if (st == '0)
            return STRETCH_W'(1);
        else
            return st;
    endfunction

endpackage

// File: rtl/decodetrig_pulse_timer.sv
// Loadable down-counter used to time the trigger stretch and the post-fire
// holdoff window.
//   clk, reset : clock and synchronous active-high reset
//   load       : load load_val this cycle (takes effect next cycle)
//   load_val   : number of cycles to time
//   last_o     : counter is on its final cycle (count == 1)
module decodetrig_pulse_timer
    import io_decode_sequencer_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else if (load)
            count_q <= load_val;
        else if (count_q != '0)
            count_q <= count_q - W'(1);
    end

    // A loaded value N keeps the owner in its state for exactly N cycles.
    assign last_o = (count_q == W'(1));

endmodule

// File: rtl/io_decode_sequencer.sv
// Byte-pattern trigger sequencer. Watches decoded bytes from a UART/SPI
// decoder, matches them against a masked pattern of up to 8 bytes and emits
// a stretched trigger pulse, followed by an optional holdoff window.
//   clk, reset_i        : clock and synchronous active-high reset
//   arm_i, disarm_i     : one-cycle arm / disarm requests (disarm wins)
//   byte_i, byte_valid_i: decoded byte and its one-cycle strobe
//   pattern_i, mask_i   : expected bytes (byte k at [k*8+:8]); mask bit 0 = wildcard
//   pattern_len_i       : pattern length (0 -> 1, >8 -> 8)
//   oneshot_i           : 1 = return to IDLE after a fire
//   timeout_i           : inter-byte timeout in cycles, 0 = disabled
//   stretch_i           : trigger width in cycles (0 -> 1)
//   holdoff_i           : cycles to ignore bytes after a fire
//   trig_o              : registered trigger pulse
//   armed_o             : sequencer is in any armed state
//   state_o             : current state encoding
//   match_idx_o         : bytes matched so far
//   trig_count_o        : saturating fire counter
//
// state    | meaning
// ---------+----------------------------------------------------
// IDLE     | not armed, bytes ignored, waiting for arm_i
// ARMED    | waiting for the first pattern byte
// MATCHING | part of the pattern seen, inter-byte timeout running
// FIRE     | trig_o high for the stretch period
// HOLDOFF  | post-fire window, bytes ignored
module io_decode_sequencer
    import io_decode_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  arm_i,
    input  logic                  disarm_i,
    input  logic [BYTE_W-1:0]     byte_i,
    input  logic                  byte_valid_i,
    input  logic [63:0]           pattern_i,
    input  logic [MAX_LEN-1:0]    mask_i,
    input  logic [LEN_W-1:0]      pattern_len_i,
    input  logic                  oneshot_i,
    input  logic [TIMEOUT_W-1:0]  timeout_i,
    input  logic [STRETCH_W-1:0]  stretch_i,
    input  logic [HOLDOFF_W-1:0]  holdoff_i,
    output logic                  trig_o,
    output logic                  armed_o,
    output logic [2:0]            state_o,
    output logic [LEN_W-1:0]      match_idx_o,
    output logic [TRIG_CNT_W-1:0] trig_count_o
);

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        idx_q, idx_d;
    logic [TIMEOUT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [TRIG_CNT_W-1:0]   trig_cnt_q;
    logic                    trig_q;

    logic [63:0]             pat_q;
    logic [MAX_LEN-1:0]      mask_q;
    logic [LEN_W-1:0]        len_q;
    logic                    oneshot_q;
    logic [TIMEOUT_W-1:0]    timeout_q;
    logic [STRETCH_W-1:0]    stretch_q;
    logic [HOLDOFF_W-1:0]    holdoff_q;

    logic                    latch_cfg;
    logic                    fire_entry;
    logic                    holdoff_load;
    logic                    stretch_last;
    logic                    holdoff_last;

    logic [BYTE_W-1:0]       exp_byte;
    logic                    hit_cur;
    logic                    hit_first;
    logic [LEN_W-1:0]        idx_inc;
    logic                    tmo_hit;

    assign exp_byte  = pat_q[{idx_q[2:0], 3'b000} +: BYTE_W];
    assign hit_cur   = !mask_q[idx_q[2:0]] || (byte_i == exp_byte);
    assign hit_first = !mask_q[0] || (byte_i == pat_q[BYTE_W-1:0]);
    assign idx_inc   = idx_q + LEN_W'(1);
    // Counter value is the number of idle MATCHING cycles already elapsed;
    // this cycle would be the one that reaches the timeout.
    assign tmo_hit   = (timeout_q != '0) &&
                       (({1'b0, tmo_cnt_q} + 17'd1) == {1'b0, timeout_q});

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tmo_cnt_d    = tmo_cnt_q;
        latch_cfg    = 1'b0;
        fire_entry   = 1'b0;
        holdoff_load = 1'b0;

        if (disarm_i) begin
            state_d   = ST_IDLE;
            idx_d     = '0;
            tmo_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    idx_d = '0;
                    if (arm_i) begin
                        state_d   = ST_ARMED;
                        latch_cfg = 1'b1;
                    end
                end
                ST_ARMED, ST_MATCHING: begin
                    if (byte_valid_i) begin
                        // A byte always wins over a coincident timeout.
                        tmo_cnt_d = '0;
                        if (hit_cur) begin
                            if (idx_inc == len_q) begin
                                state_d    = ST_FIRE;
                                idx_d      = '0;
                                fire_entry = 1'b1;
                            end else begin
                                state_d = ST_MATCHING;
                                idx_d   = idx_inc;
                            end
                        end else if (hit_first) begin
                            state_d = ST_MATCHING;
                            idx_d   = LEN_W'(1);
                        end else begin
                            state_d = ST_ARMED;
                            idx_d   = '0;
                        end
                    end else if (state_q == ST_MATCHING) begin
                        if (tmo_hit) begin
                            state_d   = ST_ARMED;
                            idx_d     = '0;
                            tmo_cnt_d = '0;
                        end else if (timeout_q != '0) begin
                            tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
                        end
                    end
                end
                ST_FIRE: begin
                    idx_d = '0;
                    if (stretch_last) begin
                        if (holdoff_q != '0) begin
                            state_d      = ST_HOLDOFF;
                            holdoff_load = 1'b1;
                        end else begin
                            state_d = oneshot_q ? ST_IDLE : ST_ARMED;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    idx_d = '0;
                    if (holdoff_last)
                        state_d = oneshot_q ? ST_IDLE : ST_ARMED;
                end
                default: begin
                    state_d   = ST_IDLE;
                    idx_d     = '0;
                    tmo_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tmo_cnt_q  <= '0;
            trig_cnt_q <= '0;
            trig_q     <= 1'b0;
            pat_q      <= '0;
            mask_q     <= '0;
            len_q      <= '0;
            oneshot_q  <= 1'b0;
            timeout_q  <= '0;
            stretch_q  <= '0;
            holdoff_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_cnt_q <= tmo_cnt_d;
            trig_q    <= (state_d == ST_FIRE);
            if (fire_entry && (trig_cnt_q != '1))
                trig_cnt_q <= trig_cnt_q + TRIG_CNT_W'(1);
            if (latch_cfg) begin
                pat_q     <= pattern_i;
                mask_q    <= mask_i;
                len_q     <= eff_len(pattern_len_i);
                oneshot_q <= oneshot_i;
                timeout_q <= timeout_i;
                stretch_q <= eff_stretch(stretch_i);
                holdoff_q <= holdoff_i;
            end
        end
    end

    decodetrig_pulse_timer #(.W(TIMER_W)) u_stretch_timer (
        .clk      (clk),
        .reset    (reset_i),
        .load     (fire_entry),
        .load_val (TIMER_W'(stretch_q)),
        .last_o   (stretch_last)
    );

    decodetrig_pulse_timer #(.W(TIMER_W)) u_holdoff_timer (
        .clk      (clk),
        .reset    (reset_i),
        .load     (holdoff_load),
        .load_val (TIMER_W'(holdoff_q)),
        .last_o   (holdoff_last)
    );

    assign trig_o       = trig_q;
    assign armed_o      = (state_q == ST_ARMED) || (state_q == ST_MATCHING) ||
                          (state_q == ST_FIRE)  || (state_q == ST_HOLDOFF);
    assign state_o      = state_q;
    assign match_idx_o  = idx_q;
    assign trig_count_o = trig_cnt_q;

endmodule
